// File: rtl/feature_seq_ctrl.sv
// Feature sequencer: runs LBP then histogram engines, banks their words, drains them to the classifier.
// Optional watchdog per engine phase is compiled in with `define FEATSEQ_TIMEOUT_EN.
module feature_seq_ctrl #(
  parameter int NUM_FEAT       = 17,
  parameter int IDX_W          = 5,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk_100,
  input  logic              reset_n,
  input  logic              feature_start,
  output logic              lbp_start,
  input  logic              lbp_done,
  output logic              hist_start,
  input  logic              hist_done,
  input  logic              cap_valid,
  input  logic [IDX_W-1:0]  cap_idx,
  input  logic [DATA_W-1:0] cap_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done_features,
  output logic              incomplete,
  output logic              timeout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LBP,
    ST_HIST,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_FEAT - 1);
  localparam logic [IDX_W:0]   NUM_FEAT_X = (IDX_W + 1)'(NUM_FEAT);

  state_t              r_state;
  logic [DATA_W-1:0]   r_bank [NUM_FEAT];
  logic [NUM_FEAT-1:0] r_written;
  logic [IDX_W-1:0]    r_out_idx;
  logic                r_lbp_start;
  logic                r_hist_start;
  logic                r_out_valid;
  logic                r_done;
  logic                r_incomplete;
  logic                r_timeout;

  logic w_cap_phase;
  logic w_idx_in_range;
  logic w_cap_ok;
  logic w_cap_bad;
  logic w_fire;
  logic w_expired;

  assign w_cap_phase    = (r_state == ST_LBP) || (r_state == ST_HIST);
  assign w_idx_in_range = ({1'b0, cap_idx} < NUM_FEAT_X);
  assign w_cap_ok       = w_cap_phase && cap_valid && w_idx_in_range;
  assign w_cap_bad      = w_cap_phase && cap_valid && !w_idx_in_range;
  assign w_fire         = r_out_valid && out_ready;

`ifdef FEATSEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_timer;

  // Counter restarts on every phase entry: it is zero in IDLE and cleared on the LBP->HIST hop.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (!w_cap_phase || (r_state == ST_LBP && lbp_done)) begin
      r_timer <= '0;
    end else if (!w_expired) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_expired = (r_timer == CNT_W'(TIMEOUT_CYCLES));
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign w_expired            = 1'b0;
`endif

  // NOTE: the bank is a small register file, so it is cleared on reset like any other state;
  // a large RAM-mapped bank would instead rely on the written bitmap alone.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_FEAT; i++) begin
        r_bank[i] <= '0;
      end
    end else if (w_cap_ok) begin
      r_bank[cap_idx] <= cap_data;
    end
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every branch
  // sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_written    <= '0;
      r_out_idx    <= '0;
      r_lbp_start  <= 1'b0;
      r_hist_start <= 1'b0;
      r_out_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_incomplete <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_lbp_start  <= 1'b0;
      r_hist_start <= 1'b0;
      r_done       <= 1'b0;

      if (w_cap_ok) begin
        r_written[cap_idx] <= 1'b1;
      end
      if (w_cap_bad) begin
        r_incomplete <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (feature_start) begin
            r_state      <= ST_LBP;
            r_lbp_start  <= 1'b1;
            r_written    <= '0;
            r_incomplete <= 1'b0;
            r_timeout    <= 1'b0;
          end
        end
        ST_LBP: begin
          if (lbp_done) begin
            r_state      <= ST_HIST;
            r_hist_start <= 1'b1;
          end else if (w_expired) begin
            r_state   <= ST_DONE;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
          end
        end
        ST_HIST: begin
          if (hist_done) begin
            r_state     <= ST_DRAIN;
            r_out_valid <= 1'b1;
            r_out_idx   <= '0;
          end else if (w_expired) begin
            r_state   <= ST_DONE;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_fire) begin
            if (r_out_idx == LAST_IDX) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b0;
              r_out_idx   <= '0;
              r_done      <= 1'b1;
              if (!(&r_written)) begin
                r_incomplete <= 1'b1;
              end
            end else begin
              r_out_idx <= r_out_idx + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read data comes straight from registers, so it is held stable for free during stalls.
  assign out_data      = (r_out_valid && r_written[r_out_idx]) ? r_bank[r_out_idx] : '0;
  assign out_valid     = r_out_valid;
  assign out_idx       = r_out_idx;
  assign out_last      = r_out_valid && (r_out_idx == LAST_IDX);
  assign lbp_start     = r_lbp_start;
  assign hist_start    = r_hist_start;
  assign busy          = (r_state != ST_IDLE);
  assign done_features = r_done;
  assign incomplete    = r_incomplete;
  assign timeout       = r_timeout;

endmodule

// File: tb/tb_feature_seq_ctrl.sv
// Directed self-checking bench for feature_seq_ctrl: normal runs, stalls, missing/bad indices,
// ignored restarts, mid-drain reset and the engine-hang behaviour for the active build.
module tb_feature_seq_ctrl;

  localparam int NUM_FEAT = 17;
  localparam int IDX_W    = 5;
  localparam int DATA_W   = 32;

  logic              clk_100 = 1'b0;
  logic              reset_n;
  logic              feature_start;
  logic              lbp_start;
  logic              lbp_done;
  logic              hist_start;
  logic              hist_done;
  logic              cap_valid;
  logic [IDX_W-1:0]  cap_idx;
  logic [DATA_W-1:0] cap_data;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done_features;
  logic              incomplete;
  logic              timeout;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] exp_bank [NUM_FEAT];

  feature_seq_ctrl #(
    .NUM_FEAT       (NUM_FEAT),
    .IDX_W          (IDX_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_100       (clk_100),
    .reset_n       (reset_n),
    .feature_start (feature_start),
    .lbp_start     (lbp_start),
    .lbp_done      (lbp_done),
    .hist_start    (hist_start),
    .hist_done     (hist_done),
    .cap_valid     (cap_valid),
    .cap_idx       (cap_idx),
    .cap_data      (cap_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_idx       (out_idx),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .done_features (done_features),
    .incomplete    (incomplete),
    .timeout       (timeout)
  );

  always #5 clk_100 = ~clk_100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done_features, 0);
    check({tag, "_inc"}, incomplete, 0);
    check({tag, "_lbp_start"}, lbp_start, 0);
  endtask

  // One image run. The LBP phase writes idx 0..13; the histogram phase writes 14..16.
  task automatic do_run(input bit ready_toggle, input bit skip15, input bit bad_idx,
                        input bit glitch, input bit same_cycle, input int lbp_hold,
                        input int abort_at);
    int  n;
    int  cyc;
    int  drained;
    int  extra_done;
    bit  exp_inc;
    exp_inc = skip15 || bad_idx;
    for (int i = 0; i < NUM_FEAT; i++) exp_bank[i] = '0;

    feature_start = 1'b1;
    tick();
    feature_start = 1'b0;
    check("lbp_start", lbp_start, 1);
    check("busy_lbp", busy, 1);
    check("inc_cleared", incomplete, 0);

    for (int k = 0; k < 14; k++) begin
      cap_valid   = 1'b1;
      cap_idx     = IDX_W'(k);
      cap_data    = 32'h100 + k;
      exp_bank[k] = 32'h100 + k;
      lbp_done    = same_cycle && (k == 13);
      tick();
      if (k == 0) check("lbp_start_1cyc", lbp_start, 0);
    end
    cap_valid = 1'b0;
    lbp_done  = 1'b0;
    if (!same_cycle) begin
      if (bad_idx) begin
        cap_valid = 1'b1;
        cap_idx   = 5'd20;
        cap_data  = 32'hDEAD_BEEF;
        tick();
        cap_valid = 1'b0;
      end
      repeat (lbp_hold) tick();
      check("busy_wait_lbp", busy, 1);
      check("no_timeout_wait", timeout, 0);
      lbp_done = 1'b1;
      tick();
      lbp_done = 1'b0;
    end
    check("hist_start", hist_start, 1);
    check("no_valid_hist", out_valid, 0);

    for (int k = 14; k < 17; k++) begin
      cap_valid     = !(skip15 && k == 15);
      cap_idx       = IDX_W'(k);
      cap_data      = 32'h200 + k;
      if (cap_valid) exp_bank[k] = 32'h200 + k;
      feature_start = glitch && (k == 14);
      hist_done     = (k == 16);
      tick();
    end
    cap_valid     = 1'b0;
    hist_done     = 1'b0;
    feature_start = 1'b0;

    n = 0;
    cyc = 0;
    drained = 0;
    while (n < NUM_FEAT && cyc < 200) begin
      out_ready     = ready_toggle ? (cyc % 2 == 1) : 1'b1;
      feature_start = glitch && (cyc == 2);
      cap_valid     = skip15 && (cyc < 3);
      cap_idx       = 5'd15;
      cap_data      = 32'h0BAD;
      if (!out_valid) begin
        check("drain_valid", out_valid, 1);
      end else begin
        drained++;
        if (abort_at >= 0 && n == abort_at) begin
          reset_n = 1'b0;
          #1;
          check_all_zero("async_rst");
          tick();
          check_all_zero("rst_edge");
          out_ready = 1'b0;
          cap_valid = 1'b0;
          feature_start = 1'b0;
          reset_n = 1'b1;
          tick();
          check("idle_after_rst", busy, 0);
          return;
        end
        check("out_idx", out_idx, n);
        check("out_data", out_data, exp_bank[n]);
        check("out_last", out_last, n == NUM_FEAT - 1);
        if (out_ready) n++;
      end
      tick();
      cyc++;
    end
    out_ready     = 1'b0;
    feature_start = 1'b0;
    cap_valid     = 1'b0;

    check("drain_words", n, NUM_FEAT);
    check("drain_cycles", drained, ready_toggle ? 34 : 17);
    check("done_pulse", done_features, 1);
    check("done_no_valid", out_valid, 0);
    check("incomplete", incomplete, exp_inc);
    check("timeout_clear", timeout, 0);
    tick();
    check("done_1cyc", done_features, 0);
    check("idle_busy", busy, 0);
    check("inc_sticky", incomplete, exp_inc);
    if (glitch) begin
      extra_done = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (done_features || busy) extra_done++;
      end
      check("no_queued_run", extra_done, 0);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    feature_start = 1'b0;
    lbp_done      = 1'b0;
    hist_done     = 1'b0;
    cap_valid     = 1'b0;
    cap_idx       = '0;
    cap_data      = '0;
    out_ready     = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    check("reset_hist_start", hist_start, 0);
    check("reset_timeout", timeout, 0);
    reset_n = 1'b1;
    tick();

    do_run(0, 0, 0, 0, 0, 5, -1);   // plain run, ready held high
    do_run(1, 0, 0, 0, 0, 5, -1);   // ready toggling
    do_run(0, 0, 0, 0, 0, 5, 7);    // reset mid-drain at idx 7
    do_run(0, 0, 0, 0, 0, 5, -1);   // clean run after reset
    do_run(0, 1, 1, 0, 0, 5, -1);   // missing idx 15 plus out-of-range idx 20
    do_run(0, 0, 0, 1, 1, 0, -1);   // restarts ignored, capture with lbp_done

`ifdef FEATSEQ_TIMEOUT_EN
    begin
      int k;
      bit seen_valid;
      k = 0;
      seen_valid = 1'b0;
      feature_start = 1'b1;
      tick();
      feature_start = 1'b0;
      check("to_lbp_start", lbp_start, 1);
      while (!done_features && k < 300) begin
        tick();
        k++;
        if (out_valid) seen_valid = 1'b1;
      end
      check("to_latency_ok", (k >= 101 && k <= 102), 1);
      check("to_flag", timeout, 1);
      check("to_no_valid", seen_valid, 0);
      tick();
      check("to_idle", busy, 0);
      check("to_sticky", timeout, 1);
    end
`else
    do_run(0, 0, 0, 0, 0, 150, -1); // engine slow well past any watchdog limit: no timeout
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
